uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Receive-side companion to the UART0 debug stream: it accepts ASCII bytes that the SAMD51 forwards from USB CDC-ACM, assembles them into line-terminated commands, and drives proxy control outputs. It also injects synthetic mouse reports into the HID path. Each command is acknowledged with a one-cycle OK/ERR code so the debug output path can echo the result.

## Interface
Parameters:
- MAX_ARGS, 10: maximum hex-digit arguments per line (10 = one 5-byte mouse report)
- TIMEOUT_CYCLES, 6_000_000: inter-byte idle limit (100 ms at 60 MHz); a partial line is discarded on expiry

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 60 MHz
- rst_n  in  1  asynchronous active-low reset
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  one-cycle strobe, byte valid
- uart_rx_error  in  1  framing/parity error strobe for the current byte
- proxy_enable  out  1  proxy enable, register
- host_mode_enable  out  1  host mode enable, register
- stats_clear  out  1  one-cycle pulse: clear packet/error counters
- inject_valid  out  1  mouse report injection valid
- inject_data  out  40  mouse report; byte k at [8k+7:8k]
- inject_ready  in  1  injection sink accepts the report
- ack_valid  out  1  one-cycle command-result strobe
- ack_code  out  2  0 = OK, 1 = ERR_SYNTAX, 2 = ERR_OVERFLOW, 3 = ERR_BUSY
- parse_error_count  out  16  saturating count of ERR acks and rx errors

## Operation
- Line grammar: opcode char, then zero or more hex digits, then CR (0x0D) or LF (0x0A).
  - Hex digits accepted: 0-9, A-F, a-f.
  - Spaces (0x20) are ignored anywhere.
  - An empty line (terminator with no opcode) is ignored, with no ack. This makes CRLF produce one command.
- Commands:
  - "P0" / "P1": set proxy_enable.
  - "H0" / "H1": set host_mode_enable.
  - "C" with no args: pulse stats_clear.
  - "M" + exactly 10 hex digits: inject. Digit pair 2k,2k+1 forms byte k, high nibble first.
  - Any other opcode, a wrong digit count, or a non-hex character gives ERR_SYNTAX.
- States:
  - IDLE: waiting for an opcode.
  - ARGS: collecting digits into a 40-bit shift register and a nibble counter.
  - DISCARD: skipping to the terminator.
  - EXEC: one cycle.
  - INJECT: holding inject_valid.
- Transitions:
  - IDLE to ARGS on a non-space, non-terminator byte.
  - ARGS to EXEC on a terminator.
  - ARGS to DISCARD on the 11th digit (result ERR_OVERFLOW) or on an invalid char (result ERR_SYNTAX). The error code is latched.
  - DISCARD to EXEC on a terminator; EXEC then issues the latched error.
  - EXEC to INJECT for a valid M command; otherwise EXEC to IDLE.
  - INJECT to IDLE on inject_ready.
- uart_rx_error: the current line is forced to DISCARD with ERR_SYNTAX, and parse_error_count increments.
- Bytes received while in EXEC or INJECT are dropped. Each dropped byte increments parse_error_count. Once, at exit from INJECT, an ERR_BUSY ack is emitted if any byte was dropped.
- Timeout: while in ARGS or DISCARD, if no byte arrives for TIMEOUT_CYCLES, return to IDLE silently.
- parse_error_count saturates at 0xFFFF. It is cleared by stats_clear.

## Timing
- Reset values: proxy_enable 0, host_mode_enable 0, stats_clear 0, inject_valid 0, inject_data 0, ack_valid 0, ack_code 0, parse_error_count 0. State is IDLE.
- Terminator strobe at cycle T:
  - EXEC runs at T+1.
  - Control registers, stats_clear, ack_valid and ack_code all update at T+2, i.e. registered, 2-cycle latency.
- inject_valid rises at T+2 and holds, with inject_data stable, until it is sampled with inject_ready=1. It falls the cycle after that. The OK ack is issued at T+2, not on acceptance.
- Back-to-back rx strobes (every cycle) are accepted in IDLE, ARGS and DISCARD.
- If the parser is in DISCARD due to an invalid character and the next strobe is a terminator, exactly one ack is produced.
- Asynchronous reset mid-line discards the partial command. If reset occurs mid-inject, inject_valid drops immediately.
- If stats_clear and a counter increment land in the same cycle, the clear wins.

## Structure
- Package uart_cmd_pkg holds:
  - ASCII constants (CR, LF, SPACE, 'P', 'H', 'C', 'M').
  - The ack code localparams.
  - The state encoding.
  - The function ascii_to_nibble (returns {valid, nibble[3:0]}).
- No sub-module is needed; a single always block plus the timeout counter covers the design.

## Test plan
- Send "P1\r\n", then "H1\n" -> proxy_enable=1 at T+2 with ack OK. Then host_mode_enable=1 with a single ack OK. The CRLF produces exactly one ack.
- Send "M0105FB0000\r" with inject_ready low for 20 cycles -> inject_data=40'h0000FB0501 held stable, inject_valid high until ready. Bytes sent during the hold give parse_error_count +n and ERR_BUSY after the injection.
- Send "X7\n", "P2\n" and "M01\n" -> three ERR_SYNTAX acks, parse_error_count=3, control outputs unchanged.
- Send "M" + 12 hex digits + "\n" -> one ERR_OVERFLOW ack, no inject.
- Send "P" then idle for TIMEOUT_CYCLES, then "1\n" -> no P command executes. The "1" is treated as an opcode, giving ERR_SYNTAX.
- Set parse_error_count to 5, then send "C\n" -> stats_clear pulses for one cycle, parse_error_count=0, ack OK. Assert rst_n low mid-line -> all outputs return to their reset values.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and ASCII helpers for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_M     = 8'h4D;

  localparam logic [1:0] ACK_OK           = 2'd0;
  localparam logic [1:0] ACK_ERR_SYNTAX   = 2'd1;
  localparam logic [1:0] ACK_ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ACK_ERR_BUSY     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_DISCARD,
    ST_EXEC,
    ST_INJECT
  } state_t;

  // Returns {valid, nibble}; valid is low for anything outside 0-9, A-F, a-f.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Assembles CR/LF-terminated ASCII commands from the UART receive stream,
// drives proxy control registers, injects mouse reports and acknowledges each line.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_ARGS       = 10,
  parameter int TIMEOUT_CYCLES = 6_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  input  logic        uart_rx_error,
  output logic        proxy_enable,
  output logic        host_mode_enable,
  output logic        stats_clear,
  output logic        inject_valid,
  output logic [39:0] inject_data,
  input  logic        inject_ready,
  output logic        ack_valid,
  output logic [1:0]  ack_code,
  output logic [15:0] parse_error_count
);

  localparam int CNT_W = $clog2(MAX_ARGS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_nx;
  logic [7:0]        opcode;
  logic [CNT_W-1:0]  nib_cnt;
  logic [39:0]       args;
  logic              err_flag;
  logic [1:0]        err_code;
  logic              dropped;
  logic [TO_W-1:0]   idle_cnt;

  logic              is_term, is_space, timeout, rx_drop;
  logic [4:0]        nib;
  logic [5:0]        nib_off;
  logic              line_start, load_nib, err_set;
  logic [1:0]        err_set_code;
  logic [1:0]        exec_code;
  logic              set_proxy, set_host, do_clear, do_inject;
  logic              busy_now, ev_byte, ev_ack_err;
  logic [16:0]       count_sum;

  assign is_term  = (uart_rx_data == ASCII_CR) || (uart_rx_data == ASCII_LF);
  assign is_space = (uart_rx_data == ASCII_SPACE);
  assign nib      = ascii_to_nibble(uart_rx_data);
  assign rx_drop  = uart_rx_valid && (state == ST_EXEC || state == ST_INJECT);
  assign timeout  = (state == ST_ARGS || state == ST_DISCARD) && !uart_rx_valid &&
                    (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Digit 2k lands in the high nibble of byte k, digit 2k+1 in its low nibble.
  assign nib_off = 6'((int'(nib_cnt) >> 1) * 8 + (nib_cnt[0] ? 0 : 4));

  always_comb begin
    exec_code = ACK_ERR_SYNTAX;
    set_proxy = 1'b0;
    set_host  = 1'b0;
    do_clear  = 1'b0;
    do_inject = 1'b0;
    if (err_flag) begin
      exec_code = err_code;
    end else begin
      case (opcode)
        ASCII_P: if (nib_cnt == CNT_W'(1) && args[7:5] == 3'd0) begin
          set_proxy = 1'b1;
          exec_code = ACK_OK;
        end
        ASCII_H: if (nib_cnt == CNT_W'(1) && args[7:5] == 3'd0) begin
          set_host  = 1'b1;
          exec_code = ACK_OK;
        end
        ASCII_C: if (nib_cnt == '0) begin
          do_clear  = 1'b1;
          exec_code = ACK_OK;
        end
        ASCII_M: if (int'(nib_cnt) == 10) begin
          do_inject = 1'b1;
          exec_code = ACK_OK;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output of this block; no latches.
    state_nx     = state;
    line_start   = 1'b0;
    load_nib     = 1'b0;
    err_set      = 1'b0;
    err_set_code = ACK_ERR_SYNTAX;
    case (state)
      ST_IDLE: begin
        if (uart_rx_valid && (uart_rx_error || (!is_term && !is_space))) begin
          line_start = 1'b1;
          if (uart_rx_error) begin
            err_set  = 1'b1;
            state_nx = ST_DISCARD;
          end else begin
            state_nx = ST_ARGS;
          end
        end
      end
      ST_ARGS: begin
        if (uart_rx_valid) begin
          if (uart_rx_error || (!is_term && !is_space && !nib[4])) begin
            err_set  = 1'b1;
            state_nx = ST_DISCARD;
          end else if (is_term) begin
            state_nx = ST_EXEC;
          end else if (!is_space) begin
            if (nib_cnt == CNT_W'(MAX_ARGS)) begin
              err_set      = 1'b1;
              err_set_code = ACK_ERR_OVERFLOW;
              state_nx     = ST_DISCARD;
            end else begin
              load_nib = 1'b1;
            end
          end
        end else if (timeout) begin
          state_nx = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (uart_rx_valid) begin
          if (uart_rx_error) err_set = 1'b1;
          else if (is_term)  state_nx = ST_EXEC;
        end else if (timeout) begin
          state_nx = ST_IDLE;
        end
      end
      ST_EXEC:   state_nx = do_inject ? ST_INJECT : ST_IDLE;
      ST_INJECT: if (inject_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign busy_now   = (state == ST_INJECT) && inject_ready && (dropped || rx_drop);
  assign ev_byte    = uart_rx_valid && (uart_rx_error || rx_drop);
  assign ev_ack_err = ((state == ST_EXEC) && (exec_code != ACK_OK)) || busy_now;
  assign count_sum  = {1'b0, parse_error_count} + {16'd0, ev_byte} + {16'd0, ev_ack_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode            <= '0;
      nib_cnt           <= '0;
      args              <= '0;
      err_flag          <= 1'b0;
      err_code          <= ACK_OK;
      dropped           <= 1'b0;
      idle_cnt          <= '0;
      proxy_enable      <= 1'b0;
      host_mode_enable  <= 1'b0;
      stats_clear       <= 1'b0;
      inject_valid      <= 1'b0;
      inject_data       <= '0;
      ack_valid         <= 1'b0;
      ack_code          <= ACK_OK;
      parse_error_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      stats_clear <= 1'b0;
      ack_valid   <= 1'b0;

      if (line_start) begin
        opcode   <= uart_rx_data;
        nib_cnt  <= '0;
        args     <= '0;
        err_flag <= 1'b0;
      end
      if (load_nib) begin
        nib_cnt <= nib_cnt + 1'b1;
        if (int'(nib_cnt) < 10) args[nib_off +: 4] <= nib[3:0];
      end
      if (err_set) begin
        err_flag <= 1'b1;
        err_code <= err_set_code;
      end

      if (uart_rx_valid || !(state == ST_ARGS || state == ST_DISCARD)) idle_cnt <= '0;
      else                                                            idle_cnt <= idle_cnt + 1'b1;

      if (state == ST_EXEC) begin
        ack_valid   <= 1'b1;
        ack_code    <= exec_code;
        stats_clear <= do_clear;
        if (set_proxy) proxy_enable     <= args[4];
        if (set_host)  host_mode_enable <= args[4];
        if (do_inject) begin
          inject_valid <= 1'b1;
          inject_data  <= args;
        end
      end

      if (state == ST_INJECT && inject_ready) begin
        inject_valid <= 1'b0;
        if (busy_now) begin
          ack_valid <= 1'b1;
          ack_code  <= ACK_ERR_BUSY;
        end
      end

      // Drops seen before an injection completes are reported once as ERR_BUSY.
      if ((state == ST_INJECT && inject_ready) || (state == ST_EXEC && !do_inject)) dropped <= 1'b0;
      else if (rx_drop)                                                           dropped <= 1'b1;

      if (state == ST_EXEC && do_clear) parse_error_count <= '0;
      else if (count_sum[16])           parse_error_count <= 16'hFFFF;
      else                              parse_error_count <= count_sum[15:0];
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected acks are queued as lines are sent
// and compared as the parser reports them.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int TIMEOUT = 200;
  localparam logic [39:0] MOUSE_RPT = 40'h0000FB0501;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic        inject_ready = 1'b0;
  logic        proxy_enable, host_mode_enable, stats_clear, inject_valid, ack_valid;
  logic [39:0] inject_data;
  logic [1:0]  ack_code;
  logic [15:0] parse_error_count;

  always #5 clk = ~clk;

  uart_cmd_parser #(.MAX_ARGS(10), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_rx_data     (rx_data),
    .uart_rx_valid    (rx_valid),
    .uart_rx_error    (rx_error),
    .proxy_enable     (proxy_enable),
    .host_mode_enable (host_mode_enable),
    .stats_clear      (stats_clear),
    .inject_valid     (inject_valid),
    .inject_data      (inject_data),
    .inject_ready     (inject_ready),
    .ack_valid        (ack_valid),
    .ack_code         (ack_code),
    .parse_error_count(parse_error_count)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_errs = 0;
  int         clear_pulses = 0;
  logic       inject_seen = 1'b0;
  logic [1:0] ack_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (stats_clear)  clear_pulses++;
      if (inject_valid) inject_seen = 1'b1;
      if (ack_valid) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 64'(ack_valid), 64'd0);
        end else begin
          logic [1:0] e;
          e = ack_q.pop_front();
          check("ack_code", 64'(ack_code), 64'(e));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Called just after a negedge; gap 0 gives back-to-back strobes.
  task automatic drive_byte(input logic [7:0] b, input int gap, input logic err);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) drive_byte(s[i], gap, 1'b0);
  endtask

  task automatic send_line(input string s, input int gap);
    drive_str(s, gap);
    drive_byte(ASCII_LF, gap, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_proxy"},  64'(proxy_enable), 64'd0);
    check({tag, "_host"},   64'(host_mode_enable), 64'd0);
    check({tag, "_clr"},    64'(stats_clear), 64'd0);
    check({tag, "_injv"},   64'(inject_valid), 64'd0);
    check({tag, "_injd"},   64'(inject_data), 64'd0);
    check({tag, "_ackv"},   64'(ack_valid), 64'd0);
    check({tag, "_ackc"},   64'(ack_code), 64'd0);
    check({tag, "_errcnt"}, 64'(parse_error_count), 64'd0);
  endtask

  initial begin
    int n_drop;
    logic stable;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // P1 with CRLF: one OK ack, two-cycle latency from the CR strobe.
    ack_q.push_back(ACK_OK);
    drive_str("P1", 3);
    drive_byte(ASCII_CR, 0, 1'b0);
    check("p1_lat_ack", 64'(ack_valid), 64'd0);
    check("p1_lat_proxy", 64'(proxy_enable), 64'd0);
    @(negedge clk);
    check("p1_proxy", 64'(proxy_enable), 64'd1);
    check("p1_ack_strobe", 64'(ack_valid), 64'd1);
    @(negedge clk);
    check("p1_ack_one_cycle", 64'(ack_valid), 64'd0);
    drive_byte(ASCII_LF, 4, 1'b0);
    ack_q.push_back(ACK_OK);
    send_line("H1", 3);
    check("h1_host", 64'(host_mode_enable), 64'd1);
    check("crlf_acks_drained", 64'(ack_q.size()), 64'd0);

    // Syntax errors leave controls alone.
    for (int i = 0; i < 3; i++) ack_q.push_back(ACK_ERR_SYNTAX);
    send_line("X7", 3);
    send_line("P2", 3);
    send_line("M01", 3);
    exp_errs += 3;
    check("syn_errcnt", 64'(parse_error_count), 64'(exp_errs));
    check("syn_proxy", 64'(proxy_enable), 64'd1);
    check("syn_host", 64'(host_mode_enable), 64'd1);

    // Mouse injection held against a stalled sink, with bytes dropped meanwhile.
    inject_ready = 1'b0;
    ack_q.push_back(ACK_OK);
    drive_str("M0105FB0000", 3);
    drive_byte(ASCII_CR, 0, 1'b0);
    check("inj_lat", 64'(inject_valid), 64'd0);
    @(negedge clk);
    check("inj_rise", 64'(inject_valid), 64'd1);
    check("inj_data", 64'(inject_data), 64'(MOUSE_RPT));
    stable = 1'b1;
    n_drop = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 2) begin
        drive_byte("Z", 0, 1'b0);
        n_drop++;
      end else begin
        @(negedge clk);
      end
      if (inject_valid !== 1'b1 || inject_data !== MOUSE_RPT) stable = 1'b0;
    end
    check("inj_hold", 64'(stable), 64'd1);
    ack_q.push_back(ACK_ERR_BUSY);
    exp_errs += n_drop + 1;
    inject_ready = 1'b1;
    @(negedge clk);
    check("inj_fall", 64'(inject_valid), 64'd0);
    inject_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Eleventh digit overflows; nothing is injected.
    inject_seen = 1'b0;
    ack_q.push_back(ACK_ERR_OVERFLOW);
    send_line("M0123456789AB", 2);
    exp_errs += 1;
    check("ovf_no_inject", 64'(inject_seen), 64'd0);
    check("ovf_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Timeout discards a partial "P"; the following "1" becomes a bad opcode.
    ack_q.push_back(ACK_OK);
    send_line("P0", 3);
    check("p0_proxy", 64'(proxy_enable), 64'd0);
    drive_byte("P", 0, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    ack_q.push_back(ACK_ERR_SYNTAX);
    send_line("1", 3);
    exp_errs += 1;
    check("to_proxy", 64'(proxy_enable), 64'd0);
    check("to_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Back-to-back strobes, including invalid char followed directly by terminator.
    ack_q.push_back(ACK_OK);
    send_line("H0", 0);
    check("b2b_host", 64'(host_mode_enable), 64'd0);
    ack_q.push_back(ACK_ERR_SYNTAX);
    send_line("Pz", 0);
    exp_errs += 1;
    check("b2b_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Receive error forces the line to ERR_SYNTAX and counts the bad byte.
    ack_q.push_back(ACK_ERR_SYNTAX);
    drive_byte("P", 3, 1'b0);
    drive_byte("1", 3, 1'b1);
    send_line("", 3);
    exp_errs += 2;
    check("rxerr_proxy", 64'(proxy_enable), 64'd0);
    check("rxerr_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Counter saturation.
    for (int i = 0; i < 65541; i++) drive_byte(8'h41, 0, 1'b1);
    ack_q.push_back(ACK_ERR_SYNTAX);
    send_line("", 3);
    exp_errs = sat16(exp_errs + 65542);
    check("sat_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Clear wins over a byte dropped during the same EXEC cycle.
    clear_pulses = 0;
    ack_q.push_back(ACK_OK);
    drive_byte("C", 3, 1'b0);
    drive_byte(ASCII_LF, 0, 1'b0);
    drive_byte("Q", 0, 1'b0);
    repeat (5) @(negedge clk);
    exp_errs = 0;
    check("clr_pulses", 64'(clear_pulses), 64'd1);
    check("clr_errcnt", 64'(parse_error_count), 64'(exp_errs));

    // Reset during an injection drops inject_valid immediately.
    ack_q.push_back(ACK_OK);
    send_line("M0105FB0000", 2);
    check("rst_inj_pre", 64'(inject_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_inj");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-line discards the partial "H".
    drive_byte("H", 3, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_q.push_back(ACK_ERR_SYNTAX);
    send_line("1", 3);
    exp_errs = 1;
    check("rst_line_host", 64'(host_mode_enable), 64'd0);
    check("rst_line_errcnt", 64'(parse_error_count), 64'(exp_errs));

    repeat (5) @(negedge clk);
    check("acks_pending", 64'(ack_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
